// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM state encoding,
// display mode codes and two-digit BCD upper limits for hour and minute.
// Optional build macro used by alarm_ctrl: ALARM_BLINK_EN.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    RING    = 3'd3,
    SNOOZE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_IDLE    = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;
  localparam logic [1:0] MODE_ALERT   = 2'd3;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // Ringing and snoozing both present as ALERT on the display path.
  function automatic logic [1:0] mode_of(input state_e s);
    case (s)
      SET_HR:       mode_of = MODE_SET_HR;
      SET_MIN:      mode_of = MODE_SET_MIN;
      RING, SNOOZE: mode_of = MODE_ALERT;
      default:      mode_of = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD incrementer: returns val_i + 1 in BCD when inc is high,
// wrapping MAX -> 00; returns val_i unchanged otherwise. Purely combinational,
// no backpressure. Ports: inc, val_i[7:0] (current value), val_o[7:0] (next).
module bcd2_counter
  import alarm_pkg::*;
#(
  parameter logic [7:0] MAX = MIN_MAX
) (
  input  logic       inc,
  input  logic [7:0] val_i,
  output logic [7:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (inc) begin
      if (val_i == MAX) begin
        val_o = 8'h00;
      end else if (val_i[3:0] >= 4'd9) begin
        // Ones digit rolls over into the tens digit.
        val_o = {val_i[7:4] + 4'd1, 4'd0};
      end else begin
        val_o = {val_i[7:4], val_i[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller downstream of the BCD time-of-day chain: stores an HH:MM
// alarm, rings a buzzer on match with snooze and auto-timeout. All outputs are
// registered (one clk after the causing input); button pulses are never held off.
// Ports: clk, reset (async, active-high), sec_tick, running-time BCD digits,
// btn_mode/btn_inc/btn_off pulses; outputs alarm digits, mode, armed, buzzer, blink.
// Build macro ALARM_BLINK_EN: blink toggles per sec_tick while setting; else 1.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter logic [7:0]  RESET_HR    = 8'h07,
  parameter logic [7:0]  RESET_MIN   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_off,
  output logic [3:0] al_hr_tens,
  output logic [3:0] al_hr_ones,
  output logic [3:0] al_min_tens,
  output logic [3:0] al_min_ones,
  output logic [1:0] mode,
  output logic       armed,
  output logic       buzzer,
  output logic       blink
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [7:0]    al_hr_q, al_hr_d;
  logic [7:0]    al_min_q, al_min_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          match_q, match_d;
  logic [1:0]    mode_q, mode_d;
  logic          buzzer_q, buzzer_d;
  logic          hr_inc, min_inc;
  logic          trigger;

  // Only the alarm minute boundary (ss == 00) matches; the rising edge fires once.
  assign match_d = armed_q
                && ({hr_tens, hr_ones} == al_hr_q)
                && ({min_tens, min_ones} == al_min_q)
                && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign trigger = match_d && !match_q;

  // Increment only when no higher-priority button is present this cycle.
  assign hr_inc  = (state_q == SET_HR)  && btn_inc && !btn_mode && !btn_off;
  assign min_inc = (state_q == SET_MIN) && btn_inc && !btn_mode && !btn_off;

  bcd2_counter #(.MAX(HR_MAX))  u_hr_cnt  (.inc(hr_inc),  .val_i(al_hr_q),  .val_o(al_hr_d));
  bcd2_counter #(.MAX(MIN_MAX)) u_min_cnt (.inc(min_inc), .val_i(al_min_q), .val_o(al_min_d));

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_off) begin
          armed_d = ~armed_q;
        end else if (btn_mode) begin
          state_d = SET_HR;
        end else if (trigger) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end
      end
      SET_HR: begin
        if (btn_off)       state_d = IDLE;
        else if (btn_mode) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (btn_off) begin
          state_d = IDLE;
        end else if (btn_mode) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end
      RING: begin
        if (btn_off) begin
          state_d = IDLE;
        end else if (btn_inc) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) state_d = IDLE;
          else                         ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (btn_off) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    mode_d   = mode_of(state_d);
    buzzer_d = (state_d == RING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      al_hr_q    <= RESET_HR;
      al_min_q   <= RESET_MIN;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      match_q    <= 1'b0;
      mode_q     <= MODE_IDLE;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match_d;
      mode_q     <= mode_d;
      buzzer_q   <= buzzer_d;
    end
  end

`ifdef ALARM_BLINK_EN
  logic blink_ph_q, blink_ph_d;

  // Phase only advances while staying inside the set states; any exit parks it at 1.
  always_comb begin
    blink_ph_d = 1'b1;
    if ((state_q == SET_HR || state_q == SET_MIN) &&
        (state_d == SET_HR || state_d == SET_MIN)) begin
      blink_ph_d = sec_tick ? ~blink_ph_q : blink_ph_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_ph_q <= 1'b1;
    else       blink_ph_q <= blink_ph_d;
  end

  assign blink = blink_ph_q;
`else
  assign blink = 1'b1;
`endif

  assign al_hr_tens  = al_hr_q[7:4];
  assign al_hr_ones  = al_hr_q[3:0];
  assign al_min_tens = al_min_q[7:4];
  assign al_min_ones = al_min_q[3:0];
  assign mode        = mode_q;
  assign armed       = armed_q;
  assign buzzer      = buzzer_q;

endmodule
